// File: rtl/pipe_drain_fifo_pkg.sv
// Shared definitions for the pipeline drain FIFO.
//   PROTO_WIDTH  : default word width of the valid/data/stall protocol
//   DEFAULT_CW   : default width of the accepted-word counter
//   CNT_SAT_DEF  : saturation value (all-ones) of the default-width counter
//   clog2()      : constant ceil(log2) used to size pointers
package pipe_drain_fifo_pkg;

    localparam int PROTO_WIDTH = 32;
    localparam int DEFAULT_CW  = 16;
    localparam logic [DEFAULT_CW-1:0] CNT_SAT_DEF = {DEFAULT_CW{1'b1}};

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipe_drain_fifo_if.sv
// Handshake bundle of the drain FIFO.
// Upstream side : v_i/data_i carry a word, stall_o asks upstream to hold it.
// Reader side   : v_o/data_o present the FIFO head (show-ahead), rd_i pops it.
// Handshake: a word moves upstream->FIFO in a cycle where v_i=1 and stall_o=0;
// a word moves FIFO->reader in a cycle where v_o=1 and rd_i=1. rd_i with
// v_o=0 is an underflow and moves nothing.
// Modports: slave = the FIFO, master = the agent driving both sides.
interface pipe_drain_fifo_if
    import pipe_drain_fifo_pkg::*;
#(
    parameter int WIDTH = PROTO_WIDTH
);
    logic             v_i;
    logic [WIDTH-1:0] data_i;
    logic             stall_o;
    logic             v_o;
    logic [WIDTH-1:0] data_o;
    logic             rd_i;

    modport slave (
        input  v_i,
        input  data_i,
        output stall_o,
        output v_o,
        output data_o,
        input  rd_i
    );

    modport master (
        output v_i,
        output data_i,
        input  stall_o,
        input  v_o,
        input  data_o,
        output rd_i
    );
endinterface

// File: rtl/pipe_drain_fifo_mem.sv
// drain_fifo_mem: DEPTH x WIDTH register array, one synchronous write port and
// one asynchronous read port. Storage is not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data at raddr
module drain_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/pipe_drain_fifo.sv
// pipe_drain_fifo: terminal consumer of the valid/data/stall pipeline.
// Buffers upstream words in a FIFO, stalls upstream when full and exposes the
// head on a show-ahead read port. Also counts accepted words (saturating) and
// keeps a sticky underflow flag.
//   clk     : clock, rising edge
//   reset   : synchronous, active-low
//   bus     : handshake bundle (slave side)
//   level_o : occupancy 0..DEPTH
//   count_o : words accepted since reset, saturating at all-ones
//   err_o   : sticky, set by rd_i while v_o is low
module pipe_drain_fifo
    import pipe_drain_fifo_pkg::*;
#(
    parameter  int WIDTH = PROTO_WIDTH,
    parameter  int DEPTH = 8,
    parameter  int CW    = DEFAULT_CW,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    pipe_drain_fifo_if.slave    bus,
    output logic [AW:0]         level_o,
    output logic [CW-1:0]       count_o,
    output logic                err_o
);
    localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] CNT_SAT    = {CW{1'b1}};

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic [AW:0]      level_next;
    logic [CW-1:0]    count;
    logic             err;
    logic             full;
    logic             not_empty;
    logic             accept;
    logic             pop;
    logic [WIDTH-1:0] head;

    // Full and empty come from the level register alone, so stall_o and v_o
    // have no combinational path from v_i or rd_i.
    assign full      = (level == LEVEL_FULL);
    assign not_empty = (level != '0);
    assign accept    = bus.v_i & ~full;
    assign pop       = bus.rd_i & not_empty;

    always_comb begin
        level_next = level;
        case ({accept, pop})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            level <= level_next;
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (count != CNT_SAT) begin
                    count <= count + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (bus.rd_i && !not_empty) begin
                err <= 1'b1;
            end
        end
    end

    drain_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (bus.data_i),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign bus.stall_o = full;
    assign bus.v_o     = not_empty;
    // Stale storage is hidden while empty.
    assign bus.data_o  = not_empty ? head : '0;
    assign level_o     = level;
    assign count_o     = count;
    assign err_o       = err;
endmodule

// File: tb/tb_pipe_drain_fifo.sv
module tb_pipe_drain_fifo;
    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CW    = 5;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic [AW:0]   level_o;
    logic [CW-1:0] count_o;
    logic          err_o;

    pipe_drain_fifo_if #(.WIDTH(W)) bus ();

    pipe_drain_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .level_o (level_o),
        .count_o (count_o),
        .err_o   (err_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: queue of buffered words plus counter and flag
    logic [W-1:0] exp_q[$];
    int           m_count;
    bit           m_err;

    int n_cmp;
    int n_fail;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : '0;
        chk({tag, ".v_o"},     W'(bus.v_o),     W'(exp_q.size() != 0));
        chk({tag, ".stall_o"}, W'(bus.stall_o), W'(exp_q.size() == DEPTH));
        chk({tag, ".level_o"}, W'(level_o),     W'(exp_q.size()));
        chk({tag, ".count_o"}, W'(count_o),     W'(m_count));
        chk({tag, ".err_o"},   W'(err_o),       W'(m_err));
        chk({tag, ".data_o"},  bus.data_o,      head);
    endtask

    // driver: apply current inputs across one rising edge, update model,
    // return at the following falling edge
    task automatic cycle();
        bit acc;
        bit pp;
        bit under;
        acc   = bus.v_i && (exp_q.size() != DEPTH);
        pp    = bus.rd_i && (exp_q.size() != 0);
        under = bus.rd_i && (exp_q.size() == 0);
        @(posedge clk);
        if (!reset) begin
            exp_q.delete();
            m_count = 0;
            m_err   = 1'b0;
        end else begin
            if (under) m_err = 1'b1;
            if (pp) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back(bus.data_i);
                if (m_count != CNT_MAX) m_count++;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit rd);
        bus.v_i    = v;
        bus.data_i = d;
        bus.rd_i   = rd;
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        m_count = 0;
        m_err   = 1'b0;
        reset   = 1'b0;
        drive(1'b0, '0, 1'b0);
        @(negedge clk);

        // reset then idle
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        check_all("reset_idle");
        chk("reset_idle.level_const", W'(level_o), W'(0));

        // fill to full with 0x10..0x17
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, W'(32'h10 + i), 1'b0);
            cycle();
            check_all("fill");
        end
        chk("fill.level8", W'(level_o), W'(8));
        chk("fill.stall", W'(bus.stall_o), W'(1));
        // held 9th word is not written
        drive(1'b1, 32'h18, 1'b0);
        cycle();
        check_all("full_hold");
        chk("full_hold.count8", W'(count_o), W'(8));
        chk("full_hold.head", bus.data_o, 32'h10);

        // drain at full: one pop while 0x18 is held
        drive(1'b1, 32'h18, 1'b1);
        cycle();
        check_all("drain_pop");
        chk("drain_pop.head", bus.data_o, 32'h11);
        chk("drain_pop.stall", W'(bus.stall_o), W'(0));
        drive(1'b1, 32'h18, 1'b0);
        cycle();
        check_all("drain_accept");
        chk("drain_accept.count9", W'(count_o), W'(9));
        chk("drain_accept.level8", W'(level_o), W'(8));

        // drain down to level 3
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, 1'b1);
            cycle();
            check_all("drain_to3");
        end

        // streaming across pointer wrap at level 3
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, W'($urandom), 1'b1);
            cycle();
            check_all("stream");
            chk("stream.level3", W'(level_o), W'(3));
        end

        // empty the FIFO, then underflow
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1);
            cycle();
            check_all("empty");
        end
        drive(1'b0, '0, 1'b1);
        cycle();
        check_all("underflow");
        chk("underflow.err", W'(err_o), W'(1));
        drive(1'b1, 32'hAB, 1'b0);
        cycle();
        check_all("after_underflow");
        chk("after_underflow.head", bus.data_o, 32'hAB);
        chk("after_underflow.v_o", W'(bus.v_o), W'(1));

        // random traffic; also drives the narrow counter into saturation
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 3) == 0));
            cycle();
            check_all("random");
        end

        // reset mid-operation at level 5
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, W'($urandom), 1'b0);
            cycle();
        end
        drive(1'b0, '0, 1'b0);
        check_all("pre_reset");
        chk("pre_reset.level5", W'(level_o), W'(5));
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        check_all("mid_reset");
        chk("mid_reset.level0", W'(level_o), W'(0));
        chk("mid_reset.count0", W'(count_o), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
